// File: rtl/vga_disc_pkg.sv
// rtl/vga_disc_pkg.sv - shared constants, state encoding and motion helper for the disc renderer
// Ports: none (package).
package vga_disc_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int H_MAX      = 639;
   localparam int V_MAX      = 479;
   localparam int PIPE_DEPTH = 3;
   localparam int COLOR_W    = 12;
   localparam int CX0        = 320;
   localparam int CY0        = 240;

   typedef enum logic [1:0] {
      WAIT,
      UPDATE,
      HOLD
   } motion_state_t;

   // One axis of the bouncing position: coordinate plus direction (1 = increasing).
   typedef struct packed {
      logic [9:0] pos;
      logic       dir;
   } axis_t;

   // Next position for one axis. The edge test looks one step ahead so the
   // disc never crosses the visible border; on a bounce it steps back instead.
   function automatic axis_t axis_step(input logic [9:0] pos,
                                       input logic       dir,
                                       input int         max_pos,
                                       input int         step,
                                       input int         radius);
      int    p;
      axis_t r;
      p     = int'(pos);
      r.pos = pos;
      r.dir = dir;
      if (dir) begin
         if (p + step + radius > max_pos) begin
            r.dir = 1'b0;
            r.pos = 10'(p - step);
         end else begin
            r.pos = 10'(p + step);
         end
      end else begin
         if (p < step + radius) begin
            r.dir = 1'b1;
            r.pos = 10'(p + step);
         end else begin
            r.pos = 10'(p - step);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/disc_renderer_if.sv
// rtl/disc_renderer_if.sv - video timing in / colour and sync out bundle
// Ports: pix_en, hcount, vcount, blank, hsync_in, vsync_in from the sync generator;
//        rgb, hsync_out, vsync_out towards the DAC/pins.
interface disc_renderer_if;
   import vga_disc_pkg::*;

   logic               pix_en;
   logic [9:0]         hcount;
   logic [9:0]         vcount;
   logic               blank;
   logic               hsync_in;
   logic               vsync_in;
   logic [COLOR_W-1:0] rgb;
   logic               hsync_out;
   logic               vsync_out;

   modport master (
      output pix_en, hcount, vcount, blank, hsync_in, vsync_in,
      input  rgb, hsync_out, vsync_out
   );

   modport slave (
      input  pix_en, hcount, vcount, blank, hsync_in, vsync_in,
      output rgb, hsync_out, vsync_out
   );

endinterface

// File: rtl/disc_motion.sv
// rtl/disc_motion.sv - once-per-frame bouncing position of the disc centre
// Ports: clk, reset (async, active-high); pix_en, hcount, vcount frame timing;
//        move_en enables motion; cx, cy registered disc centre.
module disc_motion
   import vga_disc_pkg::*;
#(
   parameter int RADIUS = 40,
   parameter int STEP   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       move_en,
   output logic [9:0] cx,
   output logic [9:0] cy
);

   motion_state_t state;
   logic          dir_x;
   logic          dir_y;
   logic          tick;
   axis_t         nx;
   axis_t         ny;

   // First pixel of the first line below the visible area.
   assign tick = pix_en && (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);

   assign nx = axis_step(cx, dir_x, H_MAX, STEP, RADIUS);
   assign ny = axis_step(cy, dir_y, V_MAX, STEP, RADIUS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WAIT;
         cx    <= 10'(CX0);
         cy    <= 10'(CY0);
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else begin
         case (state)
            WAIT: begin
               if (tick) state <= move_en ? UPDATE : HOLD;
            end
            UPDATE: begin
               cx    <= nx.pos;
               dir_x <= nx.dir;
               cy    <= ny.pos;
               dir_y <= ny.dir;
               state <= HOLD;
            end
            HOLD: begin
               // Re-arm only once the next frame has started, so repeated
               // ticks during vertical blank cannot move the disc twice.
               if (vcount == 10'd0) state <= WAIT;
            end
            default: state <= WAIT;
         endcase
      end
   end

endmodule

// File: rtl/disc_renderer.sv
// rtl/disc_renderer.sv - 3-stage pix_en-gated disc colouring pipeline with matched sync delay
// Ports: clk, reset (async, active-high); vga (slave) timing in / rgb and syncs out;
//        move_en enables disc motion; fg_color, bg_color live colour inputs.
module disc_renderer
   import vga_disc_pkg::*;
#(
   parameter int RADIUS = 40,
   parameter int STEP   = 2
) (
   input  logic               clk,
   input  logic               reset,
   disc_renderer_if.slave     vga,
   input  logic               move_en,
   input  logic [COLOR_W-1:0] fg_color,
   input  logic [COLOR_W-1:0] bg_color
);

   localparam logic [20:0] R_SQ = 21'(RADIUS * RADIUS);

   logic [9:0]          cx;
   logic [9:0]          cy;

   logic signed [10:0]  dx;
   logic signed [10:0]  dy;
   logic [9:0]          abs_dx;
   logic [9:0]          abs_dy;
   logic [19:0]         sq_x;
   logic [19:0]         sq_y;
   logic [20:0]         sum;
   logic [COLOR_W-1:0]  rgb_q;

   // blank only needs two registers here: the third stage is rgb_q itself.
   logic [1:0]            blank_q;
   logic [PIPE_DEPTH-1:0] hs_q;
   logic [PIPE_DEPTH-1:0] vs_q;

   disc_motion #(
      .RADIUS (RADIUS),
      .STEP   (STEP)
   ) u_motion (
      .clk     (clk),
      .reset   (reset),
      .pix_en  (vga.pix_en),
      .hcount  (vga.hcount),
      .vcount  (vga.vcount),
      .move_en (move_en),
      .cx      (cx),
      .cy      (cy)
   );

   // Squaring the magnitude keeps the multiplier unsigned; |dx| <= 639 fits 10 bits.
   assign abs_dx = dx[10] ? 10'(-dx) : dx[9:0];
   assign abs_dy = dy[10] ? 10'(-dy) : dy[9:0];
   assign sum    = {1'b0, sq_x} + {1'b0, sq_y};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dx      <= '0;
         dy      <= '0;
         sq_x    <= '0;
         sq_y    <= '0;
         rgb_q   <= '0;
         blank_q <= '1;
         hs_q    <= '1;
         vs_q    <= '1;
      end else if (vga.pix_en) begin
         dx      <= $signed({1'b0, vga.hcount}) - $signed({1'b0, cx});
         dy      <= $signed({1'b0, vga.vcount}) - $signed({1'b0, cy});
         sq_x    <= 20'(abs_dx) * 20'(abs_dx);
         sq_y    <= 20'(abs_dy) * 20'(abs_dy);
         if (blank_q[1])
            rgb_q <= '0;
         else if (sum <= R_SQ)
            rgb_q <= fg_color;
         else
            rgb_q <= bg_color;
         blank_q <= {blank_q[0], vga.blank};
         hs_q    <= {hs_q[PIPE_DEPTH-2:0], vga.hsync_in};
         vs_q    <= {vs_q[PIPE_DEPTH-2:0], vga.vsync_in};
      end
   end

   assign vga.rgb       = rgb_q;
   assign vga.hsync_out = hs_q[PIPE_DEPTH-1];
   assign vga.vsync_out = vs_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_disc_renderer.sv
// tb/tb_disc_renderer.sv - self-checking bench for disc_renderer
module tb_disc_renderer;
   import vga_disc_pkg::*;

   localparam int R  = 40;
   localparam int ST = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        move_en;
   logic [11:0] fg_color;
   logic [11:0] bg_color;

   disc_renderer_if vif ();

   disc_renderer #(.RADIUS(R), .STEP(ST)) dut (
      .clk      (clk),
      .reset    (reset),
      .vga      (vif),
      .move_en  (move_en),
      .fg_color (fg_color),
      .bg_color (bg_color)
   );

   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int mcx, mcy;
   bit mdx, mdy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mcx = 320; mcy = 240; mdx = 1; mdy = 1;
   endfunction

   function automatic void model_axis(inout int c, inout bit d, input int lim);
      if (d) begin
         if (c + ST + R > lim) begin d = 0; c = c - ST; end
         else c = c + ST;
      end else begin
         if (c < ST + R) begin d = 1; c = c + ST; end
         else c = c - ST;
      end
   endfunction

   function automatic void model_frame(input bit mv);
      if (mv) begin
         model_axis(mcx, mdx, 639);
         model_axis(mcy, mdy, 479);
      end
   endfunction

   function automatic logic [11:0] exp_pix(input int h, input int v, input bit b,
                                           input logic [11:0] fg, input logic [11:0] bg);
      int ddx, ddy;
      ddx = h - mcx;
      ddy = v - mcy;
      if (b) return 12'h000;
      return (ddx * ddx + ddy * ddy <= R * R) ? fg : bg;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int h, input int v, input bit b, input bit hs, input bit vs);
      vif.hcount   = 10'(h);
      vif.vcount   = 10'(v);
      vif.blank    = b;
      vif.hsync_in = hs;
      vif.vsync_in = vs;
   endtask

   task automatic strobe();
      vif.pix_en = 1'b1;
      step();
      vif.pix_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      model_reset();
      step();
   endtask

   task automatic frame(input bit mv);
      move_en    = mv;
      vif.hcount = 10'd0;
      vif.vcount = 10'd480;
      strobe();
      step();
      step();
      vif.vcount = 10'd0;
      step();
      step();
      vif.vcount = 10'd100;
      model_frame(mv);
      check("frame_cx", 32'(dut.u_motion.cx), 32'(mcx));
      check("frame_cy", 32'(dut.u_motion.cy), 32'(mcy));
   endtask

   typedef struct {
      int          h;
      int          v;
      bit          b;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[10];

   logic [11:0] q_rgb[$];
   bit          q_hs[$];
   bit          q_vs[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      move_en    = 1'b0;
      fg_color   = 12'hF00;
      bg_color   = 12'h00F;
      vif.pix_en = 1'b0;
      set_pix(320, 240, 0, 0, 0);
      model_reset();

      // Reset held: strobes must not move anything past the reset values.
      repeat (4) strobe();
      check("reset_rgb", 32'(vif.rgb), 32'h0);
      check("reset_hs", 32'(vif.hsync_out), 32'h1);
      check("reset_vs", 32'(vif.vsync_out), 32'h1);
      check("reset_cx", 32'(dut.u_motion.cx), 32'd320);
      check("reset_cy", 32'(dut.u_motion.cy), 32'd240);
      reset = 1'b0;
      step();

      // Latency: centre pixel shows up on exactly the third strobe.
      set_pix(320, 240, 0, 1, 1);
      strobe();
      check("lat_s1", 32'(vif.rgb), 32'h0);
      step();
      check("lat_hold", 32'(vif.rgb), 32'h0);
      strobe();
      check("lat_s2", 32'(vif.rgb), 32'h0);
      strobe();
      check("lat_s3", 32'(vif.rgb), 32'hF00);

      vecs[0] = '{360, 240, 0, 12'hF00};
      vecs[1] = '{361, 240, 0, 12'h00F};
      vecs[2] = '{348, 268, 0, 12'hF00};
      vecs[3] = '{280, 240, 0, 12'hF00};
      vecs[4] = '{279, 240, 0, 12'h00F};
      vecs[5] = '{320, 200, 0, 12'hF00};
      vecs[6] = '{320, 199, 0, 12'h00F};
      vecs[7] = '{0,   0,   0, 12'h00F};
      vecs[8] = '{320, 240, 1, 12'h000};
      vecs[9] = '{639, 479, 0, 12'h00F};
      for (int i = 0; i < 10; i++) begin
         set_pix(vecs[i].h, vecs[i].v, vecs[i].b, 1, 1);
         repeat (3) strobe();
         check($sformatf("vec%0d", i), 32'(vif.rgb), 32'(vecs[i].exp));
      end

      // hsync low pulse reappears unchanged three strobes later.
      begin
         bit pat[8];
         pat = '{1, 1, 0, 0, 1, 1, 1, 1};
         for (int i = 0; i < 8; i++) begin
            set_pix(100, 100, 1, pat[i], 1);
            strobe();
            if (i >= 2) check($sformatf("hs_pulse%0d", i), 32'(vif.hsync_out), 32'(pat[i-2]));
            step();
         end
      end

      // Motion: first frame and repeated ticks within one vertical blank.
      do_reset();
      frame(1);
      check("first_cx", 32'(dut.u_motion.cx), 32'd322);
      check("first_cy", 32'(dut.u_motion.cy), 32'd242);
      move_en    = 1'b1;
      vif.hcount = 10'd0;
      vif.vcount = 10'd480;
      vif.pix_en = 1'b1;
      repeat (10) step();
      vif.pix_en = 1'b0;
      step();
      check("multi_tick_cx", 32'(dut.u_motion.cx), 32'd324);
      vif.vcount = 10'd0;
      step();
      step();
      vif.vcount = 10'd100;
      model_frame(1);
      check("multi_tick_cy", 32'(dut.u_motion.cy), 32'd244);

      // Long run to both bounce points.
      do_reset();
      repeat (99) frame(1);
      check("cy_99", 32'(dut.u_motion.cy), 32'd438);
      frame(1);
      check("cy_100", 32'(dut.u_motion.cy), 32'd436);
      check("dir_y_100", 32'(dut.u_motion.dir_y), 32'd0);
      repeat (39) frame(1);
      check("cx_139", 32'(dut.u_motion.cx), 32'd598);
      frame(1);
      check("cx_140", 32'(dut.u_motion.cx), 32'd596);
      check("dir_x_140", 32'(dut.u_motion.dir_x), 32'd0);

      // Randomised pixel stream against the disc model, with pix_en gaps.
      fg_color = 12'($urandom_range(1, 4095));
      bg_color = fg_color ^ 12'hFFF;
      begin
         int          n;
         int          h, v;
         bit          b, hs, vs, pe;
         logic [11:0] last_rgb;
         n = 0;
         last_rgb = vif.rgb;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
               h = mcx + $urandom_range(0, 2 * R + 4) - R - 2;
               v = mcy + $urandom_range(0, 2 * R + 4) - R - 2;
               if (h < 0) h = 0;
               if (h > 639) h = 639;
               if (v < 1) v = 1;
               if (v > 479) v = 479;
            end else begin
               h = $urandom_range(0, 639);
               v = $urandom_range(1, 479);
            end
            b  = ($urandom_range(0, 7) == 0);
            hs = 1'($urandom);
            vs = 1'($urandom);
            pe = ($urandom_range(0, 3) != 0);
            set_pix(h, v, b, hs, vs);
            vif.pix_en = pe;
            step();
            vif.pix_en = 1'b0;
            if (pe) begin
               q_rgb.push_back(exp_pix(h, v, b, fg_color, bg_color));
               q_hs.push_back(hs);
               q_vs.push_back(vs);
               n++;
               if (n >= 3) begin
                  check("rnd_rgb", 32'(vif.rgb), 32'(q_rgb[n-3]));
                  check("rnd_hs", 32'(vif.hsync_out), 32'(q_hs[n-3]));
                  check("rnd_vs", 32'(vif.vsync_out), 32'(q_vs[n-3]));
               end
            end else if (n >= 3) begin
               check("rnd_stable", 32'(vif.rgb), 32'(last_rgb));
            end
            last_rgb = vif.rgb;
         end
      end

      // Motion disabled: position frozen.
      repeat (5) frame(0);
      check("frozen_cx", 32'(dut.u_motion.cx), 32'd596);

      // Asynchronous reset mid-line while the disc is off-centre.
      do_reset();
      repeat (40) frame(1);
      check("cx_40", 32'(dut.u_motion.cx), 32'd400);
      fg_color = 12'h0F0;
      set_pix(400, mcy, 0, 0, 0);
      repeat (3) strobe();
      check("pre_reset_rgb", 32'(vif.rgb), 32'h0F0);
      check("pre_reset_hs", 32'(vif.hsync_out), 32'h0);
      #5 reset = 1'b1;
      #1;
      check("async_rgb", 32'(vif.rgb), 32'h0);
      check("async_hs", 32'(vif.hsync_out), 32'h1);
      check("async_vs", 32'(vif.vsync_out), 32'h1);
      check("async_cx", 32'(dut.u_motion.cx), 32'd320);
      check("async_cy", 32'(dut.u_motion.cy), 32'd240);
      step();
      reset = 1'b0;
      model_reset();
      step();
      frame(1);
      check("post_reset_cx", 32'(dut.u_motion.cx), 32'd322);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/disc_renderer.md
# disc_renderer

Pixel-colour stage directly downstream of the 640x480 VGA sync generator. Consumes its pixel-enable strobe, `hcount`/`vcount`, `blank` and active-low syncs. Produces 12-bit RGB for a filled disc of fixed radius that bounces around the visible area, moving once per frame. Syncs are delayed through the same pipeline, so colour and sync leave the block aligned for the DAC/pins.

## Interface
Parameters:
- `RADIUS`, 40: disc radius in pixels; legal range 1..239.
- `STEP`, 2: pixels moved per axis per frame; legal range 1..RADIUS.

Ports:
- `clk`  in  1  system clock, 50 MHz; sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pix_en`  in  1  one-`clk` pixel strobe from the sync generator; all pipeline stages advance only when high.
- `hcount`  in  10  current pixel column.
- `vcount`  in  10  current line.
- `blank`  in  1  high outside the visible area.
- `hsync_in`  in  1  active-low hsync.
- `vsync_in`  in  1  active-low vsync.
- `move_en`  in  1  high enables per-frame motion.
- `fg_color`  in  12  disc colour, {R4,G4,B4}.
- `bg_color`  in  12  background colour.
- `rgb`  out  12  pixel colour.
- `hsync_out`  out  1  `hsync_in` delayed to match `rgb`.
- `vsync_out`  out  1  `vsync_in` delayed to match `rgb`.

## Operation
- Pipeline: 3 stages, each register loads only on `pix_en`.
  - S1: `dx = hcount - cx`, `dy = vcount - cy`, both 11-bit signed.
  - S2: `dx*dx` and `dy*dy`, 20-bit unsigned each.
  - S3: `sum` (21-bit) compared against `RADIUS*RADIUS` (constant).
  - `rgb` = 0 if the delayed `blank` is 1; else `fg_color` if `sum <= R²`; else `bg_color`.
  - The boundary is inclusive: `dx = RADIUS, dy = 0` is inside the disc.
- `blank`, `hsync_in` and `vsync_in` travel through 3 matching `pix_en`-gated delay registers.
- Motion FSM (`disc_motion`):
  - State `cx`, `cy` (10-bit), `dir_x`, `dir_y` (1 = increasing).
  - Frame tick: `pix_en & (vcount==480) & (hcount==0)`.
  - WAIT: on a tick with `move_en`=1, go to UPDATE. A tick with `move_en`=0 goes straight to HOLD with no move.
  - UPDATE (one `clk`), per axis:
    - Increasing: if `c+STEP+RADIUS > max` (639 for x, 479 for y), flip the direction and set `c = c-STEP`; else `c = c+STEP`.
    - Decreasing: if `c < STEP+RADIUS`, flip the direction and set `c = c+STEP`; else `c = c-STEP`.
    - Go to HOLD.
  - HOLD: wait for `vcount==0`, then go to WAIT. This guarantees at most one update per frame.
- Position changes only during vertical blank, so there is no tearing.
- `fg_color`, `bg_color` and `move_en` are sampled live and are not registered.

## Timing
- Latency: exactly 3 `pix_en` strobes from inputs to `rgb`/syncs. Outputs are stable between strobes.
- `pix_en` low holds every pipeline register.
- The FSM runs on every `clk`, not gated by `pix_en`. UPDATE lasts 1 `clk`.
- Reset values (asynchronous):
  - `rgb` = 0.
  - `hsync_out` = `vsync_out` = 1.
  - Internal delay registers: blank = 1, sync = 1.
  - `cx` = 320, `cy` = 240, `dir_x` = `dir_y` = 1, FSM state = WAIT.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, motion resumes at the next frame tick from the centre.
- A tick arriving while in HOLD is ignored.

## Structure
- Package `vga_disc_pkg`:
  - H_ACTIVE = 640, V_ACTIVE = 480.
  - H_MAX = 639, V_MAX = 479.
  - PIPE_DEPTH = 3.
  - COLOR_W = 12.
  - CX0 = 320, CY0 = 240.
  - FSM state enum {WAIT, UPDATE, HOLD}.
- Sub-module `disc_motion`: FSM plus position/direction registers. Outputs `cx`, `cy`.
- Top-level `disc_renderer`: pipeline and sync delay.

## Test plan
- Reset, then `hcount`=320, `vcount`=240, `blank`=0, `fg_color`=12'hF00 → `rgb`=12'hF00 on the 3rd `pix_en` after input; `rgb`=0 and syncs=1 while reset is held.
- Pixel (360,240) → `fg_color`; pixel (361,240) → `bg_color`=12'h00F. Pixel (348,268): sum 1568 ≤ 1600 → fg.
- Any pixel with `blank`=1 → `rgb`=0. `hsync_in` low pulse → `hsync_out` identical pulse, 3 strobes later.
- `move_en`=1: after the first frame tick → `cx`=322, `cy`=242. Holding `vcount`=480 across many ticks → only one update until `vcount` returns to 0.
- Run 139 frames → `cx`=598. Next frame: `cx`=596, `dir_x`=0. Y axis: `cy`=438 after 99 frames, then 436.
- `move_en`=0 for 5 frames → `cx`/`cy` unchanged. Reset pulse mid-line at `cx`=400 → `cx`=320 and `rgb`=0 immediately.
